// File: rtl/thresh_load_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : thresh_load_sequencer
// Purpose  : Holds a two-bank per-beam threshold table (bank 0 = threshold,
//            bank 1 = subthreshold) and, on request, shifts the whole table
//            into the trigger threshold cascade top beam first, then pulses
//            the per-bank update strobe. One request can be queued mid-load.
// Revision : 1.0  initial release
// ============================================================================
module thresh_load_sequencer #(
  parameter int          NBEAMS      = 54,
  parameter logic [17:0] INIT_THRESH = 18'd4000,
  localparam int         ADR_BITS    = 6
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                tbl_wr_i,
  input  logic                tbl_bank_i,
  input  logic [ADR_BITS-1:0] tbl_adr_i,
  input  logic [17:0]         tbl_dat_i,
  input  logic                load_i,
  input  logic [1:0]          load_mask_i,
  output logic                busy_o,
  output logic                done_o,
  output logic [35:0]         thresh_o,
  output logic [1:0]          thresh_wr_o,
  output logic [1:0]          thresh_update_o
);

  localparam logic [ADR_BITS-1:0] c_last_idx = ADR_BITS'(NBEAMS - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SHIFT  = 2'd1,
    S_UPDATE = 2'd2
  } state_t;

  // Table storage; contents come from configuration, never from reset.
  logic [17:0] r_tbl0 [0:NBEAMS-1] = '{default: INIT_THRESH};
  logic [17:0] r_tbl1 [0:NBEAMS-1] = '{default: INIT_THRESH};

  state_t              r_state, w_state_nxt;
  logic [ADR_BITS-1:0] r_idx, w_idx_nxt;
  logic                r_drain, w_drain_nxt;        // all reads of this load issued
  logic [1:0]          r_active_mask, w_active_mask_nxt;
  logic                r_pend, w_pend_nxt;
  logic [1:0]          r_pend_mask, w_pend_mask_nxt;
  logic                w_rd_en;
  logic                w_req;
  logic [1:0]          w_merged_mask;
  logic                w_adr_ok;
  logic [35:0]         r_thresh;
  logic [1:0]          r_thresh_wr;

  assign w_req         = load_i && (load_mask_i != 2'b00);
  assign w_adr_ok      = int'(tbl_adr_i) < NBEAMS;
  // A request in the UPDATE cycle joins the queued one for the chained load.
  assign w_merged_mask = r_pend_mask | (w_req ? load_mask_i : 2'b00);

  // Table write port: accepted in every state, out-of-range beams dropped.
  always_ff @(posedge clk_i) begin
    if (tbl_wr_i && w_adr_ok) begin
      if (tbl_bank_i) begin
        r_tbl1[tbl_adr_i] <= tbl_dat_i;
      end else begin
        r_tbl0[tbl_adr_i] <= tbl_dat_i;
      end
    end
  end

  // Synchronous table read doubling as the cascade output register (read-first).
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_thresh    <= '0;
      r_thresh_wr <= 2'b00;
    end else begin
      r_thresh_wr <= w_rd_en ? r_active_mask : 2'b00;
      if (w_rd_en) begin
        r_thresh <= {r_tbl1[r_idx], r_tbl0[r_idx]};
      end
    end
  end

  // Sequencer state registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state       <= S_IDLE;
      r_idx         <= '0;
      r_drain       <= 1'b0;
      r_active_mask <= 2'b00;
      r_pend        <= 1'b0;
      r_pend_mask   <= 2'b00;
    end else begin
      r_state       <= w_state_nxt;
      r_idx         <= w_idx_nxt;
      r_drain       <= w_drain_nxt;
      r_active_mask <= w_active_mask_nxt;
      r_pend        <= w_pend_nxt;
      r_pend_mask   <= w_pend_mask_nxt;
    end
  end

  // Next-state logic: issue reads top beam down, then one drain cycle so the
  // last shift lands before the update strobe, then update/chain.
  always_comb begin
    w_state_nxt       = r_state;
    w_idx_nxt         = r_idx;
    w_drain_nxt       = r_drain;
    w_active_mask_nxt = r_active_mask;
    w_pend_nxt        = r_pend;
    w_pend_mask_nxt   = r_pend_mask;
    w_rd_en           = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_req) begin
          w_state_nxt       = S_SHIFT;
          w_idx_nxt         = c_last_idx;
          w_drain_nxt       = 1'b0;
          w_active_mask_nxt = load_mask_i;
        end
      end

      S_SHIFT: begin
        if (w_req) begin
          w_pend_nxt      = 1'b1;
          w_pend_mask_nxt = r_pend_mask | load_mask_i;
        end
        if (!r_drain) begin
          w_rd_en = 1'b1;
          if (r_idx == '0) begin
            w_drain_nxt = 1'b1;
          end else begin
            w_idx_nxt = r_idx - 1'b1;
          end
        end else begin
          w_state_nxt = S_UPDATE;
        end
      end

      S_UPDATE: begin
        w_pend_nxt      = 1'b0;
        w_pend_mask_nxt = 2'b00;
        if (r_pend || w_req) begin
          w_state_nxt       = S_SHIFT;
          w_idx_nxt         = c_last_idx;
          w_drain_nxt       = 1'b0;
          w_active_mask_nxt = w_merged_mask;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign busy_o          = (r_state != S_IDLE);
  assign done_o          = (r_state == S_UPDATE);
  assign thresh_update_o = (r_state == S_UPDATE) ? r_active_mask : 2'b00;
  assign thresh_o        = r_thresh;
  assign thresh_wr_o     = r_thresh_wr;

endmodule
`default_nettype wire

// File: tb/tb_thresh_load_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_thresh_load_sequencer
// Purpose  : Directed self-checking bench for thresh_load_sequencer.
// Revision : 1.0  initial release
// ============================================================================
module tb_thresh_load_sequencer;

  localparam int NB = 54;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        tbl_wr_i;
  logic        tbl_bank_i;
  logic [5:0]  tbl_adr_i;
  logic [17:0] tbl_dat_i;
  logic        load_i;
  logic [1:0]  load_mask_i;
  logic        busy_o;
  logic        done_o;
  logic [35:0] thresh_o;
  logic [1:0]  thresh_wr_o;
  logic [1:0]  thresh_update_o;

  int n_cmp = 0;
  int n_err = 0;

  // Expected table contents, kept by hand alongside the writes below.
  logic [17:0] m0 [0:63];
  logic [17:0] m1 [0:63];

  thresh_load_sequencer #(.NBEAMS(NB), .INIT_THRESH(18'd4000)) dut (
    .clk_i           (clk),
    .rst_i           (rst_i),
    .tbl_wr_i        (tbl_wr_i),
    .tbl_bank_i      (tbl_bank_i),
    .tbl_adr_i       (tbl_adr_i),
    .tbl_dat_i       (tbl_dat_i),
    .load_i          (load_i),
    .load_mask_i     (load_mask_i),
    .busy_o          (busy_o),
    .done_o          (done_o),
    .thresh_o        (thresh_o),
    .thresh_wr_o     (thresh_wr_o),
    .thresh_update_o (thresh_update_o)
  );

  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tbl_write(input logic bank, input int adr, input int dat);
    tbl_wr_i   = 1'b1;
    tbl_bank_i = bank;
    tbl_adr_i  = 6'(adr);
    tbl_dat_i  = 18'(dat);
    tick();
    tbl_wr_i   = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    repeat (3) tick();
    n_cmp++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy_o); end
    n_cmp++; if (done_o !== 1'b0) begin n_err++; $display("FAIL reset_done got %b want 0", done_o); end
    n_cmp++; if (thresh_o !== 36'd0) begin n_err++; $display("FAIL reset_thresh got %h want 0", thresh_o); end
    n_cmp++; if (thresh_wr_o !== 2'b00) begin n_err++; $display("FAIL reset_wr got %b want 00", thresh_wr_o); end
    n_cmp++; if (thresh_update_o !== 2'b00) begin n_err++; $display("FAIL reset_update got %b want 00", thresh_update_o); end
    rst_i = 1'b0;
    tick();
    n_cmp++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL post_reset_busy got %b want 0", busy_o); end
  endtask

  task automatic test_load_bank0();
    logic [1:0] e_wr, e_up;
    logic       e_busy, e_done;
    for (int i = 0; i < NB; i++) begin
      tbl_write(1'b0, i, 1000 + i);
      m0[i] = 18'(1000 + i);
    end
    load_i = 1'b1; load_mask_i = 2'b01;
    for (int k = 1; k <= NB + 3; k++) begin
      tick();
      load_i = 1'b0; load_mask_i = 2'b00;
      e_busy = (k <= NB + 2);
      e_done = (k == NB + 2);
      e_wr   = (k >= 2 && k <= NB + 1) ? 2'b01 : 2'b00;
      e_up   = (k == NB + 2) ? 2'b01 : 2'b00;
      n_cmp++; if (busy_o !== e_busy) begin n_err++; $display("FAIL b0_busy k=%0d got %b want %b", k, busy_o, e_busy); end
      n_cmp++; if (done_o !== e_done) begin n_err++; $display("FAIL b0_done k=%0d got %b want %b", k, done_o, e_done); end
      n_cmp++; if (thresh_wr_o !== e_wr) begin n_err++; $display("FAIL b0_wr k=%0d got %b want %b", k, thresh_wr_o, e_wr); end
      n_cmp++; if (thresh_update_o !== e_up) begin n_err++; $display("FAIL b0_update k=%0d got %b want %b", k, thresh_update_o, e_up); end
      if (k >= 2 && k <= NB + 1) begin
        n_cmp++; if (thresh_o !== {m1[NB+1-k], m0[NB+1-k]}) begin n_err++;
          $display("FAIL b0_data k=%0d got %h want %h", k, thresh_o, {m1[NB+1-k], m0[NB+1-k]}); end
      end
      if (k >= NB + 2) begin
        n_cmp++; if (thresh_o[17:0] !== m0[0]) begin n_err++; $display("FAIL b0_hold k=%0d got %0d want %0d", k, thresh_o[17:0], m0[0]); end
      end
    end
  endtask

  task automatic test_load_both();
    logic [1:0] e_wr, e_up;
    for (int i = 0; i < NB; i++) begin
      tbl_write(1'b1, i, 2000 + i);
      m1[i] = 18'(2000 + i);
    end
    load_i = 1'b1; load_mask_i = 2'b11;
    for (int k = 1; k <= NB + 3; k++) begin
      tick();
      load_i = 1'b0; load_mask_i = 2'b00;
      e_wr = (k >= 2 && k <= NB + 1) ? 2'b11 : 2'b00;
      e_up = (k == NB + 2) ? 2'b11 : 2'b00;
      n_cmp++; if (thresh_wr_o !== e_wr) begin n_err++; $display("FAIL both_wr k=%0d got %b want %b", k, thresh_wr_o, e_wr); end
      n_cmp++; if (thresh_update_o !== e_up) begin n_err++; $display("FAIL both_update k=%0d got %b want %b", k, thresh_update_o, e_up); end
      if (k >= 2 && k <= NB + 1) begin
        n_cmp++; if (thresh_o !== {m1[NB+1-k], m0[NB+1-k]}) begin n_err++;
          $display("FAIL both_data k=%0d got %h want %h", k, thresh_o, {m1[NB+1-k], m0[NB+1-k]}); end
      end
    end
    n_cmp++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL both_busy_end got %b want 0", busy_o); end
  endtask

  task automatic test_ignored();
    load_i = 1'b1; load_mask_i = 2'b00;
    for (int k = 1; k <= 3; k++) begin
      tick();
      n_cmp++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL zero_mask_busy k=%0d got %b want 0", k, busy_o); end
    end
    load_i = 1'b0;
    tbl_write(1'b0, 60, 12345);
    tick();
    n_cmp++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL ignored_busy got %b want 0", busy_o); end
  endtask

  task automatic test_back_to_back();
    logic [1:0] e_wr, e_up;
    logic       e_busy;
    int         n_done = 0;
    load_i = 1'b1; load_mask_i = 2'b01;
    for (int k = 1; k <= 2 * NB + 7; k++) begin
      tick();
      load_i      = (k == 5) || (k == 10);
      load_mask_i = (k == 5) ? 2'b10 : ((k == 10) ? 2'b01 : 2'b00);
      if (done_o === 1'b1) n_done++;
      e_busy = (k <= 2 * NB + 4);
      e_wr   = (k >= 2 && k <= NB + 1) ? 2'b01 :
               ((k >= NB + 4 && k <= 2 * NB + 3) ? 2'b11 : 2'b00);
      e_up   = (k == NB + 2) ? 2'b01 : ((k == 2 * NB + 4) ? 2'b11 : 2'b00);
      n_cmp++; if (busy_o !== e_busy) begin n_err++; $display("FAIL q_busy k=%0d got %b want %b", k, busy_o, e_busy); end
      n_cmp++; if (thresh_wr_o !== e_wr) begin n_err++; $display("FAIL q_wr k=%0d got %b want %b", k, thresh_wr_o, e_wr); end
      n_cmp++; if (thresh_update_o !== e_up) begin n_err++; $display("FAIL q_update k=%0d got %b want %b", k, thresh_update_o, e_up); end
      if (k >= NB + 4 && k <= 2 * NB + 3) begin
        n_cmp++; if (thresh_o !== {m1[2*NB+3-k], m0[2*NB+3-k]}) begin n_err++;
          $display("FAIL q_data k=%0d got %h want %h", k, thresh_o, {m1[2*NB+3-k], m0[2*NB+3-k]}); end
      end
    end
    load_i = 1'b0; load_mask_i = 2'b00;
    n_cmp++; if (n_done !== 2) begin n_err++; $display("FAIL q_done_count got %0d want 2", n_done); end
  endtask

  task automatic test_write_during_load();
    m0[10] = 18'd7;  // written before its read: new value expected
    load_i = 1'b1; load_mask_i = 2'b01;
    for (int k = 1; k <= NB + 3; k++) begin
      tick();
      load_i = 1'b0; load_mask_i = 2'b00;
      tbl_wr_i   = (k == 43) || (k == 49);
      tbl_bank_i = 1'b0;
      tbl_adr_i  = (k == 43) ? 6'd10 : 6'd5;
      tbl_dat_i  = (k == 43) ? 18'd7 : 18'd9;
      if (k >= 2 && k <= NB + 1) begin
        n_cmp++; if (thresh_o[17:0] !== m0[NB+1-k]) begin n_err++;
          $display("FAIL wdl_data k=%0d got %0d want %0d", k, thresh_o[17:0], m0[NB+1-k]); end
      end
    end
    tbl_wr_i = 1'b0;
    m0[5] = 18'd9;  // written in its read cycle: old value was shifted
  endtask

  task automatic test_reset_mid_load();
    load_i = 1'b1; load_mask_i = 2'b01;
    for (int k = 1; k <= 20; k++) begin
      tick();
      load_i      = (k == 5);
      load_mask_i = (k == 5) ? 2'b10 : 2'b00;
    end
    rst_i = 1'b1;
    #1;
    n_cmp++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL rml_busy got %b want 0", busy_o); end
    n_cmp++; if (done_o !== 1'b0) begin n_err++; $display("FAIL rml_done got %b want 0", done_o); end
    n_cmp++; if (thresh_o !== 36'd0) begin n_err++; $display("FAIL rml_thresh got %h want 0", thresh_o); end
    n_cmp++; if (thresh_wr_o !== 2'b00) begin n_err++; $display("FAIL rml_wr got %b want 00", thresh_wr_o); end
    n_cmp++; if (thresh_update_o !== 2'b00) begin n_err++; $display("FAIL rml_update got %b want 00", thresh_update_o); end
    tick();
    rst_i = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      tick();
      n_cmp++; if (busy_o !== 1'b0 || thresh_update_o !== 2'b00) begin n_err++;
        $display("FAIL rml_quiet k=%0d got busy=%b upd=%b want busy=0 upd=00", k, busy_o, thresh_update_o); end
    end
  endtask

  task automatic test_reload_after_reset();
    logic [1:0] e_wr;
    load_i = 1'b1; load_mask_i = 2'b11;
    for (int k = 1; k <= NB + 3; k++) begin
      tick();
      load_i = 1'b0; load_mask_i = 2'b00;
      e_wr = (k >= 2 && k <= NB + 1) ? 2'b11 : 2'b00;
      n_cmp++; if (thresh_wr_o !== e_wr) begin n_err++; $display("FAIL rl_wr k=%0d got %b want %b", k, thresh_wr_o, e_wr); end
      if (k >= 2 && k <= NB + 1) begin
        n_cmp++; if (thresh_o !== {m1[NB+1-k], m0[NB+1-k]}) begin n_err++;
          $display("FAIL rl_data k=%0d got %h want %h", k, thresh_o, {m1[NB+1-k], m0[NB+1-k]}); end
      end
    end
    n_cmp++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL rl_busy_end got %b want 0", busy_o); end
  endtask

  initial begin
    rst_i = 1'b1; tbl_wr_i = 1'b0; tbl_bank_i = 1'b0; tbl_adr_i = '0; tbl_dat_i = '0;
    load_i = 1'b0; load_mask_i = 2'b00;
    for (int i = 0; i < 64; i++) begin
      m0[i] = 18'd4000;
      m1[i] = 18'd4000;
    end
    test_reset();
    test_load_bank0();
    test_load_both();
    test_ignored();
    test_back_to_back();
    test_write_during_load();
    test_reset_mid_load();
    test_reload_after_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
